// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator: fractional oversample tick plus bit tick,
// with shadowed divisor updates and a resync input for start-bit phase alignment.
module baud_tick_gen #(
    parameter int unsigned DIV_W            = 16,
    parameter int unsigned FRAC_W           = 4,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DEFAULT_DIV_INT  = 324,
    parameter int unsigned DEFAULT_DIV_FRAC = 8,
    localparam int unsigned OSW             = $clog2(OVERSAMPLE)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              os_tick,
    output logic              bit_tick,
    output logic [OSW-1:0]    os_idx,
    output logic              load_pending
);

    localparam logic [OSW-1:0]    OsLast      = OSW'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0]  DefDivInt   = DIV_W'(DEFAULT_DIV_INT);
    localparam logic [FRAC_W-1:0] DefDivFrac  = FRAC_W'(DEFAULT_DIV_FRAC);

    logic [DIV_W:0]    cnt_q;
    logic [FRAC_W-1:0] acc_q;
    logic              ext_q;
    logic [OSW-1:0]    os_idx_q;
    logic [DIV_W-1:0]  act_int_q, shd_int_q;
    logic [FRAC_W-1:0] act_frac_q, shd_frac_q;
    logic              pend_q;
    logic              os_tick_q, bit_tick_q;

    logic              wrap;
    logic [DIV_W:0]    wrap_cnt;
    logic [FRAC_W:0]   acc_sum;
    logic [OSW-1:0]    os_idx_next;

    always_comb begin
        wrap_cnt    = {1'b0, act_int_q} + {{DIV_W{1'b0}}, ext_q};
        wrap        = en && (cnt_q == wrap_cnt);
        // MSB of the sum is the carry that stretches the following period by one cycle
        acc_sum     = {1'b0, acc_q} + {1'b0, act_frac_q};
        os_idx_next = (os_idx_q == OsLast) ? '0 : os_idx_q + 1'b1;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            ext_q      <= 1'b0;
            os_idx_q   <= '0;
            act_int_q  <= DefDivInt;
            act_frac_q <= DefDivFrac;
            shd_int_q  <= DefDivInt;
            shd_frac_q <= DefDivFrac;
            pend_q     <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            if (!en) begin
                cnt_q    <= '0;
                acc_q    <= '0;
                ext_q    <= 1'b0;
                os_idx_q <= '0;
                if (div_load) begin
                    shd_int_q  <= div_int;
                    shd_frac_q <= div_frac;
                    pend_q     <= 1'b1;
                end else if (pend_q) begin
                    act_int_q  <= shd_int_q;
                    act_frac_q <= shd_frac_q;
                    pend_q     <= 1'b0;
                end
            end else if (resync || wrap) begin
                if (resync) begin
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    ext_q    <= 1'b0;
                    os_idx_q <= '0;
                end else begin
                    cnt_q      <= '0;
                    acc_q      <= acc_sum[FRAC_W-1:0];
                    ext_q      <= acc_sum[FRAC_W];
                    os_idx_q   <= os_idx_next;
                    os_tick_q  <= 1'b1;
                    bit_tick_q <= (os_idx_q == OsLast);
                end
                // A load coinciding with the period boundary governs the very next period
                if (div_load) begin
                    act_int_q  <= div_int;
                    act_frac_q <= div_frac;
                    shd_int_q  <= div_int;
                    shd_frac_q <= div_frac;
                end else if (pend_q) begin
                    act_int_q  <= shd_int_q;
                    act_frac_q <= shd_frac_q;
                end
                pend_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (div_load) begin
                    shd_int_q  <= div_int;
                    shd_frac_q <= div_frac;
                    pend_q     <= 1'b1;
                end
            end
        end
    end

    assign os_tick      = os_tick_q;
    assign bit_tick     = bit_tick_q;
    assign os_idx       = os_idx_q;
    assign load_pending = pend_q;

endmodule
